// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the architectural PC, issues one icache fetch
// at a time and hands {inst, pc, fault} to decode over valid/ready. Redirects
// from later stages replace the PC and squash any response still in flight.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   ifu_arvalid/ready fetch address handshake, ifu_raddr = pc word address
//   ifu_rvalid/rready instruction response handshake, ifu_rdata/ifu_rresp payload
//   redirect_valid/pc PC redirect from branch/jump/trap logic
//   idu_valid/ready   decode handshake, idu_inst/idu_pc/idu_fault payload
module ifu_fetch #(
  parameter int unsigned DATA_LEN = 32,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ifu_arvalid,
  input  logic                ifu_arready,
  output logic [DATA_LEN-3:0] ifu_raddr,
  input  logic                ifu_rvalid,
  output logic                ifu_rready,
  input  logic [31:0]         ifu_rdata,
  input  logic [2:0]          ifu_rresp,
  input  logic                redirect_valid,
  input  logic [DATA_LEN-1:0] redirect_pc,
  output logic                idu_valid,
  input  logic                idu_ready,
  output logic [31:0]         idu_inst,
  output logic [DATA_LEN-1:0] idu_pc,
  output logic                idu_fault
);

  localparam int unsigned INST_W = 32;
  localparam logic [DATA_LEN-1:0] RESET_PC_EXT = DATA_LEN'(RESET_PC);
  localparam logic [DATA_LEN-1:0] PC_STEP      = DATA_LEN'(4);
  localparam logic [DATA_LEN-1:0] ALIGN_MASK   = ~DATA_LEN'(3);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_STALL = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] pc_q, pc_d;
  logic                drop_q, drop_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                fault_q, fault_d;

  logic                ar_hs, r_hs, idu_hs;
  logic [DATA_LEN-1:0] redir_pc;

  assign ar_hs    = (state_q == S_REQ)  && ifu_arready;
  assign r_hs     = (state_q == S_WAIT) && ifu_rvalid;
  assign idu_hs   = (state_q == S_HOLD) && idu_ready;
  assign redir_pc = redirect_pc & ALIGN_MASK;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  // Next-state logic; redirect beats an idu handshake in HOLD
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_REQ;
      S_REQ:   if (ar_hs) state_d = S_WAIT;
      S_WAIT: begin
        if (r_hs) state_d = (drop_q || redirect_valid) ? S_REQ : S_HOLD;
      end
      S_HOLD: begin
        if (redirect_valid)  state_d = S_REQ;
        else if (idu_hs)     state_d = fault_q ? S_STALL : S_REQ;
      end
      S_STALL: if (redirect_valid) state_d = S_REQ;
      default: state_d = S_BOOT;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    ifu_arvalid = (state_q == S_REQ);
    ifu_rready  = (state_q == S_WAIT);
    idu_valid   = (state_q == S_HOLD);
    ifu_raddr   = pc_q[DATA_LEN-1:2];
    idu_inst    = inst_q;
    idu_pc      = pc_q;
    idu_fault   = fault_q;
  end

  // Datapath next values: pc, stale-response drop flag, captured instruction
  always_comb begin
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
          // request for the old PC already left; squash its response
          if (ar_hs) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_hs) begin
          if (drop_q || redirect_valid) begin
            drop_d = 1'b0;
            if (redirect_valid) pc_d = redir_pc;
          end else begin
            inst_d  = ifu_rdata;
            fault_d = |ifu_rresp;
          end
        end else if (redirect_valid) begin
          pc_d   = redir_pc;
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid)          pc_d = redir_pc;
        else if (idu_hs && !fault_q) pc_d = pc_q + PC_STEP;
      end
      S_STALL: if (redirect_valid) pc_d = redir_pc;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC_EXT;
      drop_q  <= 1'b0;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed vector table, hand-written corner sequences,
// then randomized traffic against a program-order reference model.
module tb_ifu_fetch;

  logic        clk, rst_n;
  logic        ifu_arvalid, ifu_arready;
  logic [29:0] ifu_raddr;
  logic        ifu_rvalid, ifu_rready;
  logic [31:0] ifu_rdata;
  logic [2:0]  ifu_rresp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        idu_valid, idu_ready;
  logic [31:0] idu_inst, idu_pc;
  logic        idu_fault;

  ifu_fetch #(.DATA_LEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_raddr(ifu_raddr),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .idu_valid(idu_valid), .idu_ready(idu_ready), .idu_inst(idu_inst),
    .idu_pc(idu_pc), .idu_fault(idu_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic arr, input logic rv,
                       input logic [31:0] rd, input logic [2:0] rr,
                       input logic rdv, input logic [31:0] rdpc, input logic ir);
    rst_n = rst; ifu_arready = arr; ifu_rvalid = rv; ifu_rdata = rd; ifu_rresp = rr;
    redirect_valid = rdv; redirect_pc = rdpc; idu_ready = ir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: outputs expected in the current cycle, inputs applied this cycle
  typedef struct {
    logic rst, arr, rv; logic [31:0] rdata; logic [2:0] rresp;
    logic rdv; logic [31:0] rdpc; logic ir;
    logic eav, err, eiv; logic [29:0] eraddr;
    logic cd; logic [31:0] einst, epc; logic ef;
  } vec_t;

  function automatic vec_t mk(logic rst, logic arr, logic rv, logic [31:0] rdata, logic [2:0] rresp,
                              logic rdv, logic [31:0] rdpc, logic ir,
                              logic eav, logic err, logic eiv, logic [29:0] eraddr,
                              logic cd, logic [31:0] einst, logic [31:0] epc, logic ef);
    vec_t v;
    v.rst = rst; v.arr = arr; v.rv = rv; v.rdata = rdata; v.rresp = rresp;
    v.rdv = rdv; v.rdpc = rdpc; v.ir = ir;
    v.eav = eav; v.err = err; v.eiv = eiv; v.eraddr = eraddr;
    v.cd = cd; v.einst = einst; v.epc = epc; v.ef = ef;
    return v;
  endfunction

  // Reference icache contents and fault map
  function automatic logic [31:0] mem(logic [29:0] wa);
    logic [31:0] a;
    a = {wa, 2'b00};
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic flt(logic [29:0] wa);
    return wa[5:0] == 6'h15;
  endfunction

  vec_t tbl[$];

  // Random-phase reference state
  logic [31:0] arch_pc;
  logic        stalled;
  logic        pending;
  logic [29:0] paddr;
  int          pcnt;
  logic        prev_hold;
  logic [31:0] prev_inst, prev_pc;
  logic        prev_fault;
  int          delivered;
  int          idle;
  int          since;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    // release, first fetch, redirect in WAIT with stale response, HOLD backpressure
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,30'h2000_0000, 1,32'h0,32'h8000_0000,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,0,0,30'h2000_0000, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,30'h2000_0000, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,30'h2000_0000, 0,0,0,0));
    tbl.push_back(mk(1,0,1,32'h0000_0413,0,0,0,0, 0,1,0,30'h2000_0000, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 0,0,1,30'h2000_0000, 1,32'h0000_0413,32'h8000_0000,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,30'h2000_0001, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,0,0,30'h2000_0001, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,32'h8000_0100,0, 0,1,0,30'h2000_0001, 0,0,0,0));
    tbl.push_back(mk(1,0,1,32'hDEAD_BEEF,0,0,0,0, 0,1,0,30'h2000_0040, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,30'h2000_0040, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,0,0,30'h2000_0040, 0,0,0,0));
    tbl.push_back(mk(1,0,1,32'h0010_0093,0,0,0,0, 0,1,0,30'h2000_0040, 0,0,0,0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,1,30'h2000_0040, 1,32'h0010_0093,32'h8000_0100,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 0,0,1,30'h2000_0040, 1,32'h0010_0093,32'h8000_0100,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,30'h2000_0041, 0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].arr, tbl[i].rv, tbl[i].rdata, tbl[i].rresp,
            tbl[i].rdv, tbl[i].rdpc, tbl[i].ir);
      chk($sformatf("vec%0d.arvalid", i), 64'(ifu_arvalid), 64'(tbl[i].eav));
      chk($sformatf("vec%0d.rready", i),  64'(ifu_rready),  64'(tbl[i].err));
      chk($sformatf("vec%0d.idu_valid", i), 64'(idu_valid), 64'(tbl[i].eiv));
      chk($sformatf("vec%0d.raddr", i),   64'(ifu_raddr),   64'(tbl[i].eraddr));
      if (tbl[i].cd) begin
        chk($sformatf("vec%0d.inst", i),  64'(idu_inst),  64'(tbl[i].einst));
        chk($sformatf("vec%0d.pc", i),    64'(idu_pc),    64'(tbl[i].epc));
        chk($sformatf("vec%0d.fault", i), 64'(idu_fault), 64'(tbl[i].ef));
      end
      tick();
    end

    // access fault -> STALL until redirect
    drive(1,1,0,0,0,0,0,0); chk("flt.arvalid", 64'(ifu_arvalid), 64'd1); tick();
    drive(1,0,1,32'h1234_5678,3'd2,0,0,0); tick();
    drive(1,0,0,0,0,0,0,1);
    chk("flt.idu_valid", 64'(idu_valid), 64'd1);
    chk("flt.idu_fault", 64'(idu_fault), 64'd1);
    chk("flt.idu_pc", 64'(idu_pc), 64'h8000_0104);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1,1,0,0,0,0,0,1);
      chk($sformatf("stall%0d.arvalid", k), 64'(ifu_arvalid), 64'd0);
      chk($sformatf("stall%0d.idu_valid", k), 64'(idu_valid), 64'd0);
      tick();
    end
    drive(1,0,0,0,0,1,32'h8000_0203,0); tick();
    drive(1,0,0,0,0,0,0,0);
    chk("unstall.arvalid", 64'(ifu_arvalid), 64'd1);
    chk("unstall.raddr", 64'(ifu_raddr), 64'h2000_0080);

    // redirect and idu handshake together: redirect wins
    drive(1,1,0,0,0,0,0,0); tick();
    drive(1,0,1,32'h0000_0013,0,0,0,0); tick();
    drive(1,0,0,0,0,1,32'h8000_0300,1);
    chk("both.idu_valid", 64'(idu_valid), 64'd1);
    chk("both.idu_pc", 64'(idu_pc), 64'h8000_0200);
    chk("both.idu_inst", 64'(idu_inst), 64'h13);
    tick();
    drive(1,0,0,0,0,0,0,0);
    chk("both.raddr", 64'(ifu_raddr), 64'h2000_00C0);

    // PC wrap at the top of the address space, then reset during WAIT
    drive(1,0,0,0,0,1,32'hFFFF_FFFE,0); tick();
    drive(1,1,0,0,0,0,0,0); chk("wrap.raddr_top", 64'(ifu_raddr), 64'h3FFF_FFFF); tick();
    drive(1,0,1,32'h0000_0077,0,0,0,0); tick();
    drive(1,0,0,0,0,0,0,1); chk("wrap.idu_pc", 64'(idu_pc), 64'hFFFF_FFFC); tick();
    drive(1,1,0,0,0,0,0,0);
    chk("wrap.arvalid", 64'(ifu_arvalid), 64'd1);
    chk("wrap.raddr_zero", 64'(ifu_raddr), 64'd0);
    tick();
    drive(0,0,1,32'h0BAD_0BAD,0,0,0,0); chk("rstw.rready", 64'(ifu_rready), 64'd1); tick();
    drive(1,0,1,32'h0BAD_0BAD,0,0,0,0);
    chk("boot.arvalid", 64'(ifu_arvalid), 64'd0);
    chk("boot.rready", 64'(ifu_rready), 64'd0);
    chk("boot.idu_valid", 64'(idu_valid), 64'd0);
    chk("boot.idu_inst", 64'(idu_inst), 64'd0);
    chk("boot.idu_fault", 64'(idu_fault), 64'd0);
    tick();
    drive(1,1,0,0,0,0,0,0);
    chk("refetch.arvalid", 64'(ifu_arvalid), 64'd1);
    chk("refetch.raddr", 64'(ifu_raddr), 64'h2000_0000);
    tick();
    drive(1,0,1,32'h0000_0055,0,0,0,0); tick();
    drive(1,0,0,0,0,0,0,1);
    chk("refetch.idu_inst", 64'(idu_inst), 64'h55);
    chk("refetch.idu_pc", 64'(idu_pc), 64'h8000_0000);
    tick();

    // Randomized traffic against the program-order model
    drive(0,0,0,0,0,0,0,0); tick(); tick();
    arch_pc = 32'h8000_0000; stalled = 0; pending = 0; paddr = '0; pcnt = 0;
    prev_hold = 0; prev_inst = '0; prev_pc = '0; prev_fault = 0;
    delivered = 0; idle = 0; since = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        rst, rv, rdv, arr, ir, ar_hs, r_hs, i_hs;
      logic [31:0] rd, rdpc;
      logic [2:0]  rr;
      rst  = !(cyc == 1500 || cyc == 1501);
      rv   = pending && (pcnt == 0);
      rd   = rv ? mem(paddr) : $urandom;
      rr   = (rv && flt(paddr)) ? 3'(1 + $urandom_range(0, 6)) : 3'd0;
      rdv  = rst && (since >= 1) && ($urandom_range(0, stalled ? 3 : 15) == 0);
      rdpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                         : (32'h8000_0000 + 32'($urandom_range(0, 1023)));
      arr  = 1'($urandom_range(0, 1));
      ir   = ($urandom_range(0, 3) != 0);
      drive(rst, arr, rv, rd, rr, rdv, rdpc, ir);

      if (!rst) begin
        since = 0; arch_pc = 32'h8000_0000; stalled = 0; pending = 0;
        prev_hold = 0; idle = 0;
      end else begin
        ar_hs = ifu_arvalid && arr;
        r_hs  = rv && ifu_rready;
        i_hs  = idu_valid && ir && !rdv;
        if (ifu_arvalid) chk("rnd.no_fetch_in_stall", 64'(stalled), 64'd0);
        if (idu_valid)   chk("rnd.no_valid_in_stall", 64'(stalled), 64'd0);
        if (prev_hold) begin
          chk("rnd.hold_valid", 64'(idu_valid), 64'd1);
          chk("rnd.hold_inst", 64'(idu_inst), 64'(prev_inst));
          chk("rnd.hold_pc", 64'(idu_pc), 64'(prev_pc));
          chk("rnd.hold_fault", 64'(idu_fault), 64'(prev_fault));
        end
        if (ar_hs) begin
          chk("rnd.raddr", 64'(ifu_raddr), 64'(arch_pc[31:2]));
          chk("rnd.one_outstanding", 64'(pending), 64'd0);
          pending = 1; paddr = ifu_raddr; pcnt = $urandom_range(0, 3);
        end else if (r_hs) begin
          pending = 0;
        end else if (pending && pcnt > 0) begin
          pcnt--;
        end
        if (i_hs) begin
          chk("rnd.idu_pc", 64'(idu_pc), 64'(arch_pc));
          chk("rnd.idu_inst", 64'(idu_inst), 64'(mem(arch_pc[31:2])));
          chk("rnd.idu_fault", 64'(idu_fault), 64'(flt(arch_pc[31:2])));
          delivered++;
          idle = 0;
          if (flt(arch_pc[31:2])) stalled = 1;
          else                    arch_pc = arch_pc + 32'd4;
        end
        if (rdv) begin
          arch_pc = rdpc & ~32'd3;
          stalled = 0;
          idle = 0;
        end
        prev_hold  = idu_valid && !ir && !rdv;
        prev_inst  = idu_inst; prev_pc = idu_pc; prev_fault = idu_fault;
        idle++;
        if (idle > 200) begin
          n_cmp++; n_bad++;
          $display("FAIL rnd.progress: got %0d idle cycles expected at most 200", idle);
          idle = 0;
        end
        since++;
      end
      tick();
    end
    n_cmp++;
    if (delivered < 50) begin
      n_bad++;
      $display("FAIL rnd.delivered: got %0d expected at least 50", delivered);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
